mem_master: RTL
===============

// Module: mem_master
// PURPOSE
//  Bus initiator for the byte-wide memory port (memRq/readNotWrite/addr/dataIn/dataOut).
//  Turns one 16-bit word request from the CPU datapath into two sequenced 8-bit accesses
//  (low byte, then high byte) and returns the assembled word with a one-cycle done pulse.
//  Sits between the MU0 control/datapath and the memory block; it is the only driver of memRq.
// PARAMETERS
//  WAIT_CYCLES  0  extra cycles memRq is held per byte before dataOut is sampled (0..15)
//  HI_FIRST     0  1: access high byte (odd address) first; assembled word is unchanged
// PORTS
//  clk          in   1   single clock; all state updates on rising edge
//  reset        in   1   synchronous, active-high
//  cpuReq       in   1   word request; accepted only when cpuReady=1
//  cpuWrite     in   1   1=store word, 0=load word; sampled with cpuReq
//  cpuAddr      in   7   word address; byte addresses {cpuAddr,1'b0} (lo), {cpuAddr,1'b1} (hi)
//  cpuWdata     in   16  store data; sampled with cpuReq
//  cpuReady     out  1   1 in IDLE only
//  cpuDone      out  1   one-cycle pulse: access complete (cpuRdata valid for loads)
//  cpuRdata     out  16  last completed load word {hi,lo}
//  memRq        out  1   memory request, registered
//  readNotWrite out  1   1=read, 0=write, registered
//  addr         out  8   byte address, registered
//  dataIn       out  8   write byte to memory, registered
//  dataOut      in   8   read byte from memory (combinational, 8'hFF when memRq=0)
// BEHAVIOUR
//  Reset: state=IDLE; cpuReady=1, cpuDone=0, cpuRdata=16'h0000, memRq=0, readNotWrite=1,
//   addr=8'h00, dataIn=8'h00, wait counter=0. Reset mid-access aborts: memRq=0 in the next
//   cycle, no cpuDone, latched request discarded.
//  FSM: IDLE -> BYTE0 -> BYTE1 -> DONE -> IDLE.
//   IDLE: cpuReq=1 latches cpuWrite/cpuAddr/cpuWdata; next state BYTE0. memRq=0.
//   BYTE0: memRq=1, addr=first byte address, readNotWrite=~write, dataIn=matching byte of
//    cpuWdata (low byte unless HI_FIRST). Held WAIT_CYCLES+1 cycles; on last cycle a read
//    captures dataOut into the matching half of a holding register; -> BYTE1.
//   BYTE1: same for the other byte; memRq stays 1 across the BYTE0->BYTE1 boundary, only
//    addr/dataIn change. On last cycle -> DONE.
//   DONE: memRq=0, readNotWrite=1; cpuDone=1 for exactly this cycle; loads copy holding
//    register to cpuRdata (visible same cycle as cpuDone); stores leave cpuRdata unchanged.
//  Latency (WAIT_CYCLES=W): request accepted at edge k; memRq high for 2*(W+1) cycles from
//   k+1; cpuDone high in cycle k+2W+3; cpuReady returns the following cycle. Min issue
//   interval 2W+4 cycles.
//  cpuReq while cpuReady=0 is ignored (no queue); requester must hold until accepted.
//  dataOut is never sampled while memRq=0. addr/dataIn return to 0 in IDLE/DONE.
//  Address edge: cpuAddr=7'h7F -> bytes 8'hFE, 8'hFF; no wrap, no carry into bit 8.
//  Wait counter: 4-bit, reloaded to W on entry to each byte state, decremented to 0.
// TESTING
//  1 Reset: hold reset 2 cycles -> all outputs at reset values, cpuReady=1, memRq=0.
//  2 Store cpuAddr=7'h05, cpuWdata=16'hBEEF, W=0 -> writes 8'hEF@8'h0A then 8'hBE@8'h0B
//    with readNotWrite=0 in consecutive cycles; cpuDone at k+3; cpuRdata unchanged.
//  3 Load word 7'h05 after test 2 -> addr 8'h0A,8'h0B read; cpuRdata=16'hBEEF at cpuDone.
//  4 W=2, load cpuAddr=7'h7F with mem[FE]=8'h34, mem[FF]=8'h12 -> memRq high 6 cycles,
//    cpuDone at k+7, cpuRdata=16'h1234; HI_FIRST=1 gives same word, addr order FF,FE.
//  5 Back-to-back cpuReq held high: second request accepted only after cpuReady rises;
//    cpuReq pulses while busy produce no memory activity.
//  6 Assert reset during BYTE1 of a store -> memRq=0 next cycle, no cpuDone, cpuReady=1;
//    subsequent load returns correct data.

Source files
------------

// File: rtl/mem_master.sv
// Byte-wide memory port initiator: one 16-bit word request becomes two
// sequenced byte accesses, with a one-cycle completion pulse.
module mem_master #(
    parameter int WAIT_CYCLES = 0,
    parameter bit HI_FIRST    = 1'b0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpuReq,
    input  logic        cpuWrite,
    input  logic [6:0]  cpuAddr,
    input  logic [15:0] cpuWdata,
    output logic        cpuReady,
    output logic        cpuDone,
    output logic [15:0] cpuRdata,
    output logic        memRq,
    output logic        readNotWrite,
    output logic [7:0]  addr,
    output logic [7:0]  dataIn,
    input  logic [7:0]  dataOut
);

    typedef enum logic [1:0] {IDLE, BYTE0, BYTE1, DONE} state_t;

    localparam logic [3:0] W = 4'(WAIT_CYCLES);

    state_t      state, nstate;
    logic [3:0]  cnt;
    logic        wr;
    logic [6:0]  wa;
    logic [15:0] wd;
    logic [7:0]  first;
    logic        last;

    assign last     = (cnt == 4'd0);
    assign cpuReady = (state == IDLE);
    assign cpuDone  = (state == DONE);

    always_comb begin
        nstate = state;
        unique case (state)
            IDLE:  if (cpuReq) nstate = BYTE0;
            BYTE0: if (last) nstate = BYTE1;
            BYTE1: if (last) nstate = DONE;
            DONE:  nstate = IDLE;
            default: nstate = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= nstate;
    end

    // memRq/addr/dataIn are registered so the second byte follows the
    // first without a gap in memRq.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt          <= 4'd0;
            wr           <= 1'b0;
            wa           <= 7'd0;
            wd           <= 16'h0000;
            first        <= 8'h00;
            cpuRdata     <= 16'h0000;
            memRq        <= 1'b0;
            readNotWrite <= 1'b1;
            addr         <= 8'h00;
            dataIn       <= 8'h00;
        end else begin
            unique case (state)
                IDLE: begin
                    if (cpuReq) begin
                        wr           <= cpuWrite;
                        wa           <= cpuAddr;
                        wd           <= cpuWdata;
                        cnt          <= W;
                        memRq        <= 1'b1;
                        readNotWrite <= ~cpuWrite;
                        addr         <= {cpuAddr, HI_FIRST};
                        dataIn       <= HI_FIRST ? cpuWdata[15:8]
                                                 : cpuWdata[7:0];
                    end
                end
                BYTE0: begin
                    if (last) begin
                        if (!wr) first <= dataOut;
                        cnt    <= W;
                        addr   <= {wa, ~HI_FIRST};
                        dataIn <= HI_FIRST ? wd[7:0] : wd[15:8];
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                BYTE1: begin
                    if (last) begin
                        if (!wr)
                            cpuRdata <= HI_FIRST ? {first, dataOut}
                                                 : {dataOut, first};
                        memRq        <= 1'b0;
                        readNotWrite <= 1'b1;
                        addr         <= 8'h00;
                        dataIn       <= 8'h00;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                DONE: ;
                default: ;
            endcase
        end
    end

endmodule
